// File: rtl/npc_pkg.sv
// Shared definitions for the core's memory path: MemOp (func3) codes,
// LSU FSM state encoding, default bus timeout and access-check helpers.
package npc_pkg;

  localparam int TIMEOUT_DEFAULT = 256;

  localparam logic [2:0] MEMOP_B  = 3'b000;
  localparam logic [2:0] MEMOP_H  = 3'b001;
  localparam logic [2:0] MEMOP_W  = 3'b010;
  localparam logic [2:0] MEMOP_BU = 3'b100;
  localparam logic [2:0] MEMOP_HU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_REQ  = 2'b01,
    ST_WAIT = 2'b10,
    ST_RESP = 2'b11
  } lsu_state_e;

  // Stores only have signed-looking codes; unsigned forms are load-only.
  function automatic logic op_legal(input logic wen, input logic [2:0] op);
    logic ok;
    case (op)
      MEMOP_B, MEMOP_H, MEMOP_W: ok = 1'b1;
      MEMOP_BU, MEMOP_HU:        ok = ~wen;
      default:                   ok = 1'b0;
    endcase
    return ok;
  endfunction

  function automatic logic op_misaligned(input logic [2:0] op, input logic [1:0] off);
    logic mis;
    case (op)
      MEMOP_H, MEMOP_HU: mis = off[0];
      MEMOP_W:           mis = (off != 2'b00);
      default:           mis = 1'b0;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational byte-lane logic: store data replication / strobe generation
// and load lane selection with sign or zero extension.
module lsu_align
  import npc_pkg::*;
(
  input  logic [2:0]  st_op,
  input  logic [1:0]  st_off,
  input  logic [31:0] st_wdata,
  output logic [31:0] st_data,
  output logic [3:0]  st_strb,
  input  logic [2:0]  ld_op,
  input  logic [1:0]  ld_off,
  input  logic [31:0] ld_word,
  output logic [31:0] ld_data
);

  logic [7:0]  byte_s;
  logic [15:0] half_s;

  // Store lanes: narrow data is replicated so the strobe alone picks the lane.
  always_comb begin
    st_data = st_wdata;
    st_strb = 4'b0000;
    case (st_op)
      MEMOP_B: begin
        st_data = {4{st_wdata[7:0]}};
        st_strb = 4'b0001 << st_off;
      end
      MEMOP_H: begin
        st_data = {2{st_wdata[15:0]}};
        st_strb = 4'b0011 << {st_off[1], 1'b0};
      end
      MEMOP_W: begin
        st_data = st_wdata;
        st_strb = 4'b1111;
      end
      default: begin
        st_data = 32'd0;
        st_strb = 4'b0000;
      end
    endcase
  end

  // Load lanes: pick byte/half by offset, then extend per op.
  always_comb begin
    byte_s  = 8'd0;
    half_s  = 16'd0;
    ld_data = 32'd0;
    case (ld_off)
      2'b00:   byte_s = ld_word[7:0];
      2'b01:   byte_s = ld_word[15:8];
      2'b10:   byte_s = ld_word[23:16];
      2'b11:   byte_s = ld_word[31:24];
      default: byte_s = 8'd0;
    endcase
    if (ld_off[1]) begin
      half_s = ld_word[31:16];
    end else begin
      half_s = ld_word[15:0];
    end
    case (ld_op)
      MEMOP_B:  ld_data = {{24{byte_s[7]}}, byte_s};
      MEMOP_BU: ld_data = {24'd0, byte_s};
      MEMOP_H:  ld_data = {{16{half_s[15]}}, half_s};
      MEMOP_HU: ld_data = {16'd0, half_s};
      MEMOP_W:  ld_data = ld_word;
      default:  ld_data = 32'd0;
    endcase
  end

endmodule

// File: rtl/lsu.sv
// Load/store unit: one outstanding access, IDLE -> REQ -> WAIT -> RESP.
// Optional build macro LSU_MISALIGN_TRAP_EN: misaligned halfword/word
// accesses complete with resp_err and never reach the bus.
module lsu
  import npc_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wen,
  input  logic [2:0]  req_op,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        bus_valid,
  input  logic        bus_ready,
  output logic        bus_wen,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_wstrb,
  input  logic        bus_rvalid,
  input  logic [31:0] bus_rdata
);

  localparam logic [31:0] TO_LAST = 32'(TIMEOUT - 1);

  lsu_state_e  state_r;
  logic [31:0] cnt_r;
  logic        req_ready_r, bus_valid_r, bus_wen_r;
  logic [31:0] bus_addr_r, bus_wdata_r;
  logic [3:0]  bus_wstrb_r;
  logic        resp_valid_r, resp_err_r;
  logic [31:0] resp_rdata_r;
  logic [2:0]  op_r;
  logic [1:0]  off_r;

  logic        accept_s, err_s, misalign_s, timeout_hit_s;
  logic [31:0] st_data_s, ld_data_s;
  logic [3:0]  st_strb_s;

  lsu_align u_align (
    .st_op    (req_op),
    .st_off   (req_addr[1:0]),
    .st_wdata (req_wdata),
    .st_data  (st_data_s),
    .st_strb  (st_strb_s),
    .ld_op    (op_r),
    .ld_off   (off_r),
    .ld_word  (bus_rdata),
    .ld_data  (ld_data_s)
  );

`ifdef LSU_MISALIGN_TRAP_EN
  assign misalign_s = op_misaligned(req_op, req_addr[1:0]);
`else
  assign misalign_s = 1'b0;
`endif

  assign accept_s      = req_valid && req_ready_r;
  assign err_s         = !op_legal(req_wen, req_op) || misalign_s;
  assign timeout_hit_s = (TIMEOUT != 0) && (cnt_r == TO_LAST);

  // FSM, timeout counter and all registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= ST_IDLE;
      cnt_r        <= 32'd0;
      req_ready_r  <= 1'b1;
      bus_valid_r  <= 1'b0;
      bus_wen_r    <= 1'b0;
      bus_addr_r   <= 32'd0;
      bus_wdata_r  <= 32'd0;
      bus_wstrb_r  <= 4'b0000;
      resp_valid_r <= 1'b0;
      resp_err_r   <= 1'b0;
      resp_rdata_r <= 32'd0;
      op_r         <= 3'b000;
      off_r        <= 2'b00;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (accept_s) begin
            req_ready_r <= 1'b0;
            cnt_r       <= 32'd0;
            bus_wen_r   <= req_wen;
            bus_addr_r  <= {req_addr[31:2], 2'b00};
            op_r        <= req_op;
            off_r       <= req_addr[1:0];
            if (err_s) begin
              // Rejected access: answer directly, bus stays quiet.
              state_r      <= ST_RESP;
              bus_wdata_r  <= 32'd0;
              bus_wstrb_r  <= 4'b0000;
              resp_valid_r <= 1'b1;
              resp_err_r   <= 1'b1;
              resp_rdata_r <= 32'd0;
            end else begin
              state_r     <= ST_REQ;
              bus_valid_r <= 1'b1;
              bus_wdata_r <= req_wen ? st_data_s : 32'd0;
              bus_wstrb_r <= req_wen ? st_strb_s : 4'b0000;
            end
          end
        end
        ST_REQ: begin
          // rvalid is deliberately ignored here, even alongside bus_ready.
          cnt_r <= cnt_r + 32'd1;
          if (bus_ready) begin
            state_r     <= ST_WAIT;
            bus_valid_r <= 1'b0;
          end else if (timeout_hit_s) begin
            state_r      <= ST_RESP;
            bus_valid_r  <= 1'b0;
            resp_valid_r <= 1'b1;
            resp_err_r   <= 1'b1;
            resp_rdata_r <= 32'd0;
          end
        end
        ST_WAIT: begin
          cnt_r <= cnt_r + 32'd1;
          if (bus_rvalid) begin
            state_r      <= ST_RESP;
            resp_valid_r <= 1'b1;
            resp_err_r   <= 1'b0;
            resp_rdata_r <= bus_wen_r ? 32'd0 : ld_data_s;
          end else if (timeout_hit_s) begin
            state_r      <= ST_RESP;
            resp_valid_r <= 1'b1;
            resp_err_r   <= 1'b1;
            resp_rdata_r <= 32'd0;
          end
        end
        ST_RESP: begin
          state_r      <= ST_IDLE;
          req_ready_r  <= 1'b1;
          resp_valid_r <= 1'b0;
          resp_err_r   <= 1'b0;
          resp_rdata_r <= 32'd0;
        end
        default: begin
          state_r      <= ST_IDLE;
          req_ready_r  <= 1'b1;
          bus_valid_r  <= 1'b0;
          resp_valid_r <= 1'b0;
          resp_err_r   <= 1'b0;
          resp_rdata_r <= 32'd0;
        end
      endcase
    end
  end

  assign req_ready  = req_ready_r;
  assign bus_valid  = bus_valid_r;
  assign bus_wen    = bus_wen_r;
  assign bus_addr   = bus_addr_r;
  assign bus_wdata  = bus_wdata_r;
  assign bus_wstrb  = bus_wstrb_r;
  assign resp_valid = resp_valid_r;
  assign resp_err   = resp_err_r;
  assign resp_rdata = resp_rdata_r;

endmodule

// File: tb/tb_lsu.sv
// Directed testbench for lsu (TIMEOUT=8). Inputs change 1ns after the rising
// edge and outputs are sampled at the same point, after the edge has settled.
module tb_lsu;

  logic        clk = 1'b0;
  logic        rst, req_valid, req_wen, bus_ready, bus_rvalid;
  logic [2:0]  req_op;
  logic [31:0] req_addr, req_wdata, bus_rdata;
  logic        req_ready, resp_valid, resp_err, bus_valid, bus_wen;
  logic [31:0] resp_rdata, bus_addr, bus_wdata;
  logic [3:0]  bus_wstrb;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  lsu #(.TIMEOUT(8)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_wen(req_wen), .req_op(req_op), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .bus_valid(bus_valid), .bus_ready(bus_ready), .bus_wen(bus_wen),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_wstrb(bus_wstrb),
    .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue one request in the current cycle and act as a one-cycle bus
  // (ready the cycle bus_valid is seen, rvalid the cycle after).
  task automatic run_access(input logic wen, input logic [2:0] op, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic [31:0] rdata,
                            output logic ever, output logic [31:0] baddr, output logic [31:0] bwdata,
                            output logic [3:0] bstrb, output logic bwen, output int start,
                            output int resp_c, output logic err, output logic [31:0] rd);
    int ph;
    ever = 1'b0; baddr = 32'd0; bwdata = 32'd0; bstrb = 4'd0; bwen = 1'b0;
    resp_c = -1; err = 1'b0; rd = 32'd0; ph = 0;
    start = cyc;
    req_valid = 1'b1; req_wen = wen; req_op = op; req_addr = addr; req_wdata = wdata;
    for (int c = 1; c <= 12; c++) begin
      step();
      req_valid = 1'b0;
      bus_rvalid = 1'b0;
      if (ph == 1) begin bus_ready = 1'b0; bus_rvalid = 1'b1; bus_rdata = rdata; ph = 2; end
      if (bus_valid && ph == 0) begin
        ever = 1'b1; baddr = bus_addr; bwdata = bus_wdata; bstrb = bus_wstrb; bwen = bus_wen;
        bus_ready = 1'b1; ph = 1;
      end
      if (resp_valid) begin resp_c = c; err = resp_err; rd = resp_rdata; break; end
    end
    bus_ready = 1'b0; bus_rvalid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; step(); step(); rst = 1'b0;
    checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL rst_req_ready got=%b exp=1", req_ready); end
    checks++; if (bus_valid !== 1'b0) begin failures++; $display("FAIL rst_bus_valid got=%b exp=0", bus_valid); end
    checks++; if (resp_valid !== 1'b0) begin failures++; $display("FAIL rst_resp_valid got=%b exp=0", resp_valid); end
    checks++; if (resp_err !== 1'b0) begin failures++; $display("FAIL rst_resp_err got=%b exp=0", resp_err); end
    checks++; if (resp_rdata !== 32'd0) begin failures++; $display("FAIL rst_resp_rdata got=%h exp=0", resp_rdata); end
    checks++; if (bus_wstrb !== 4'd0) begin failures++; $display("FAIL rst_bus_wstrb got=%b exp=0", bus_wstrb); end
  endtask

  task automatic test_store_word();
    logic ev, bw, er; logic [31:0] ba, bd, rd; logic [3:0] bs; int st, rc;
    run_access(1'b1, 3'b010, 32'h80000104, 32'hDEADBEEF, 32'h0, ev, ba, bd, bs, bw, st, rc, er, rd);
    checks++; if (bs !== 4'b1111) begin failures++; $display("FAIL sw_wstrb got=%b exp=1111", bs); end
    checks++; if (ba !== 32'h80000104) begin failures++; $display("FAIL sw_addr got=%h exp=80000104", ba); end
    checks++; if (bd !== 32'hDEADBEEF) begin failures++; $display("FAIL sw_wdata got=%h exp=deadbeef", bd); end
    checks++; if (bw !== 1'b1) begin failures++; $display("FAIL sw_wen got=%b exp=1", bw); end
    checks++; if (rc !== 3) begin failures++; $display("FAIL sw_latency got=%0d exp=3", rc); end
    checks++; if (er !== 1'b0) begin failures++; $display("FAIL sw_err got=%b exp=0", er); end
    checks++; if (rd !== 32'd0) begin failures++; $display("FAIL sw_rdata got=%h exp=0", rd); end
    step();
    checks++; if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin failures++; $display("FAIL sw_pulse got=%b/%b exp=0/1", resp_valid, req_ready); end
  endtask

  task automatic test_store_narrow();
    logic ev, bw, er; logic [31:0] ba, bd, rd; logic [3:0] bs; int st, rc;
    run_access(1'b1, 3'b000, 32'h80000003, 32'h000000A5, 32'h0, ev, ba, bd, bs, bw, st, rc, er, rd);
    step();
    checks++; if (bs !== 4'b1000) begin failures++; $display("FAIL sb_wstrb got=%b exp=1000", bs); end
    checks++; if (bd !== 32'hA5A5A5A5) begin failures++; $display("FAIL sb_wdata got=%h exp=a5a5a5a5", bd); end
    checks++; if (ba !== 32'h80000000) begin failures++; $display("FAIL sb_addr got=%h exp=80000000", ba); end
    run_access(1'b1, 3'b001, 32'h00000012, 32'h1234ABCD, 32'h0, ev, ba, bd, bs, bw, st, rc, er, rd);
    step();
    checks++; if (bs !== 4'b1100) begin failures++; $display("FAIL sh_wstrb got=%b exp=1100", bs); end
    checks++; if (bd !== 32'hABCDABCD) begin failures++; $display("FAIL sh_wdata got=%h exp=abcdabcd", bd); end
  endtask

  task automatic test_loads();
    logic [2:0]  ops  [5] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b010};
    logic [31:0] adrs [5] = '{32'h1002, 32'h1003, 32'h1002, 32'h1000, 32'h1000};
    logic [31:0] exps [5] = '{32'hFFFFFFFF, 32'h00000080, 32'hFFFF80FF, 32'h00007F01, 32'h80FF7F01};
    logic ev, bw, er; logic [31:0] ba, bd, rd; logic [3:0] bs; int st, rc;
    for (int i = 0; i < 5; i++) begin
      run_access(1'b0, ops[i], adrs[i], 32'hFFFFFFFF, 32'h80FF7F01, ev, ba, bd, bs, bw, st, rc, er, rd);
      step();
      checks++; if (rd !== exps[i] || er !== 1'b0) begin failures++; $display("FAIL load%0d_rdata got=%h err=%b exp=%h err=0", i, rd, er, exps[i]); end
      checks++; if (bs !== 4'b0000 || bw !== 1'b0) begin failures++; $display("FAIL load%0d_strb got=%b wen=%b exp=0000 wen=0", i, bs, bw); end
    end
  endtask

  task automatic test_illegal();
    logic ev, bw, er; logic [31:0] ba, bd, rd; logic [3:0] bs; int st, rc;
    run_access(1'b0, 3'b011, 32'h2000, 32'h0, 32'h12345678, ev, ba, bd, bs, bw, st, rc, er, rd);
    step();
    checks++; if (ev !== 1'b0 || er !== 1'b1 || rd !== 32'd0) begin failures++; $display("FAIL illegal_load got=bus%b err%b rd%h exp=bus0 err1 rd0", ev, er, rd); end
    checks++; if (rc !== 1) begin failures++; $display("FAIL illegal_latency got=%0d exp=1", rc); end
    run_access(1'b1, 3'b100, 32'h2000, 32'h55, 32'h0, ev, ba, bd, bs, bw, st, rc, er, rd);
    step();
    checks++; if (ev !== 1'b0 || er !== 1'b1) begin failures++; $display("FAIL illegal_store got=bus%b err%b exp=bus0 err1", ev, er); end
  endtask

  task automatic test_back_to_back();
    logic ev, bw, er; logic [31:0] ba, bd, rd; logic [3:0] bs; int s0, s1, rc;
    run_access(1'b0, 3'b010, 32'h3000, 32'h0, 32'hCAFEF00D, ev, ba, bd, bs, bw, s0, rc, er, rd);
    step();
    run_access(1'b0, 3'b010, 32'h3004, 32'h0, 32'h0BADF00D, ev, ba, bd, bs, bw, s1, rc, er, rd);
    checks++; if (s1 - s0 !== 4) begin failures++; $display("FAIL b2b_period got=%0d exp=4", s1 - s0); end
    checks++; if (rd !== 32'h0BADF00D || rc !== 3) begin failures++; $display("FAIL b2b_second got=%h lat%0d exp=0badf00d lat3", rd, rc); end
    step();
  endtask

  task automatic test_timeout();
    logic [31:0] a0; int held, resp_c, extra; logic stable, er, bv; logic [31:0] rd;
    held = 0; resp_c = -1; stable = 1'b1; er = 1'b0; bv = 1'b1; rd = 32'hX; a0 = 32'd0; extra = 0;
    bus_ready = 1'b0;
    req_valid = 1'b1; req_wen = 1'b1; req_op = 3'b010; req_addr = 32'h80000010; req_wdata = 32'h01020304;
    for (int c = 1; c <= 20; c++) begin
      step();
      req_valid = 1'b0;
      if (c == 1) a0 = bus_addr;
      if (resp_valid) begin resp_c = c; er = resp_err; rd = resp_rdata; bv = bus_valid; break; end
      if (bus_valid) held++;
      if (bus_addr !== a0 || bus_wstrb !== 4'b1111 || bus_wdata !== 32'h01020304) stable = 1'b0;
    end
    checks++; if (resp_c < 8 || resp_c > 10) begin failures++; $display("FAIL to_latency got=%0d exp=8..10", resp_c); end
    checks++; if (held !== resp_c - 1 || stable !== 1'b1) begin failures++; $display("FAIL to_hold got=held%0d stable%b exp=held%0d stable1", held, stable, resp_c - 1); end
    checks++; if (er !== 1'b1 || rd !== 32'd0 || bv !== 1'b0) begin failures++; $display("FAIL to_resp got=err%b rd%h bv%b exp=err1 rd0 bv0", er, rd, bv); end
    step();
    bus_rvalid = 1'b1; step(); bus_rvalid = 1'b0;
    for (int c = 0; c < 5; c++) begin if (resp_valid) extra++; step(); end
    checks++; if (extra !== 0 || req_ready !== 1'b1) begin failures++; $display("FAIL to_late_rvalid got=%0d ready%b exp=0 ready1", extra, req_ready); end
  endtask

  task automatic test_reset_in_wait();
    int extra;
    extra = 0;
    req_valid = 1'b1; req_wen = 1'b0; req_op = 3'b010; req_addr = 32'h4000; req_wdata = 32'h0;
    step(); req_valid = 1'b0; bus_ready = 1'b1;
    step(); bus_ready = 1'b0; rst = 1'b1;
    step(); rst = 1'b0;
    checks++; if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin failures++; $display("FAIL rstwait_state got=ready%b rv%b exp=ready1 rv0", req_ready, resp_valid); end
    bus_rvalid = 1'b1; bus_rdata = 32'h77777777;
    step(); bus_rvalid = 1'b0;
    for (int c = 0; c < 4; c++) begin if (resp_valid) extra++; step(); end
    checks++; if (extra !== 0) begin failures++; $display("FAIL rstwait_resp got=%0d exp=0", extra); end
  endtask

  task automatic test_misalign();
    logic ev, bw, er; logic [31:0] ba, bd, rd; logic [3:0] bs; int st, rc;
    run_access(1'b0, 3'b010, 32'h80000002, 32'h0, 32'h11223344, ev, ba, bd, bs, bw, st, rc, er, rd);
    step();
`ifdef LSU_MISALIGN_TRAP_EN
    checks++; if (ev !== 1'b0 || er !== 1'b1) begin failures++; $display("FAIL misalign_trap got=bus%b err%b exp=bus0 err1", ev, er); end
`else
    checks++; if (ba !== 32'h80000000 || er !== 1'b0) begin failures++; $display("FAIL misalign_lw got=%h err%b exp=80000000 err0", ba, er); end
    checks++; if (rd !== 32'h11223344) begin failures++; $display("FAIL misalign_rdata got=%h exp=11223344", rd); end
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_wen = 1'b0; req_op = 3'b000; req_addr = 32'd0;
    req_wdata = 32'd0; bus_ready = 1'b0; bus_rvalid = 1'b0; bus_rdata = 32'd0;
    #1;
    test_reset();
    test_store_word();
    test_store_narrow();
    test_loads();
    test_illegal();
    test_back_to_back();
    test_timeout();
    test_reset_in_wait();
    test_misalign();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
